fifo_push_arbiter: RTL and testbench

//  Shares the single 34-bit write port of a fifo_v3 instance between NUM_REQ requesters.

---
 rtl/fifo_push_arbiter.sv | 107 ++++++++++
 tb/tb_fifo_push_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter with packet lock that shares one FIFO write port among NUM_REQ requesters.
// A grant is held until the packet's last beat or MAX_BEATS accepted beats, whichever comes first.
module fifo_push_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 34,
    parameter int unsigned MAX_BEATS  = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ-1:0]              req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic                            fifo_full_i,
    output logic                            fifo_push_o,
    output logic [DATA_WIDTH-1:0]           fifo_data_o,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic                            locked_o
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          st;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   cnt;

    logic [IW-1:0]   winner;
    logic            any_valid;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   sel_inc;
    logic            has_grant;
    logic            go;
    logic            acc;
    logic            done;
    int              beats_next;
    int              idx;

    // Rotating priority scan: the lowest offset from rr_ptr wins, so scan offsets high to low.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % int'(NUM_REQ);
            if (req_valid_i[idx]) begin
                winner    = IW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sel        = (st == LOCKED) ? owner : winner;
        has_grant  = (st == LOCKED) || any_valid;
        go         = ~fifo_full_i & ~flush_i;
        acc        = has_grant & req_valid_i[sel] & go;
        sel_inc    = (int'(sel) + 1 == int'(NUM_REQ)) ? '0 : sel + IW'(1);
        beats_next = (st == LOCKED) ? int'(cnt) + 1 : 1;
        done       = req_last_i[sel] || (beats_next == int'(MAX_BEATS));
    end

    // Zero-latency port outputs; everything is held at zero while reset is asserted.
    always_comb begin
        grant_o     = '0;
        req_ready_o = '0;
        fifo_push_o = 1'b0;
        fifo_data_o = '0;
        locked_o    = 1'b0;
        if (rst_ni) begin
            if (has_grant) begin
                grant_o     = NUM_REQ'(1) << sel;
                fifo_data_o = req_data_i[sel*DATA_WIDTH +: DATA_WIDTH];
            end
            req_ready_o = grant_o & {NUM_REQ{go}};
            fifo_push_o = acc;
            locked_o    = (st == LOCKED);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            st     <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else if (acc) begin
            if (done) begin
                st     <= IDLE;
                rr_ptr <= sel_inc;
                cnt    <= '0;
            end else begin
                st    <= LOCKED;
                owner <= sel;
                cnt   <= CW'(beats_next);
            end
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomized scoreboard bench for fifo_push_arbiter against a packet-level reference model.
module tb_fifo_push_arbiter;

    localparam int NR = 4;
    localparam int DW = 34;
    localparam int MB = 8;
    localparam int NCYC = 4000;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic                 flush_i;
    logic [NR-1:0]        req_valid_i;
    logic [NR-1:0]        req_last_i;
    logic [NR*DW-1:0]     req_data_i;
    logic [NR-1:0]        req_ready_o;
    logic                 fifo_full_i;
    logic                 fifo_push_o;
    logic [DW-1:0]        fifo_data_o;
    logic [NR-1:0]        grant_o;
    logic                 locked_o;

    fifo_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .fifo_full_i (fifo_full_i),
        .fifo_push_o (fifo_push_o),
        .fifo_data_o (fifo_data_o),
        .grant_o     (grant_o),
        .locked_o    (locked_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          push;
        logic [DW-1:0] data;
        logic [NR-1:0] grant;
        logic [NR-1:0] ready;
        logic          locked;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Requester traffic: packets of random length, beat data tags requester/packet/beat.
    int pkt_len [NR];
    int beat    [NR];
    int pkt_no  [NR];
    bit up      [NR];

    // Reference model: who currently holds the port and where the next search starts.
    bit in_packet;
    int holder;
    int next_start;
    int beats_taken;
    int accepted_id;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int i);
        return {8'(i), 10'(pkt_no[i]), 16'(beat[i])};
    endfunction

    task automatic model_reset();
        in_packet   = 1'b0;
        holder      = 0;
        next_start  = 0;
        beats_taken = 0;
    endtask

    // Expected outputs for the inputs just driven, then advance the model past this cycle's edge.
    task automatic model_step(output exp_t e);
        int  g;
        bit  found;
        e = '0;
        accepted_id = -1;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        g = -1;
        found = 1'b0;
        if (in_packet) begin
            g = holder;
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (!found && req_valid_i[(next_start + k) % NR]) begin
                    g = (next_start + k) % NR;
                    found = 1'b1;
                end
            end
        end
        e.locked = in_packet;
        if (g >= 0) begin
            e.grant[g] = 1'b1;
            e.data     = req_data_i[g*DW +: DW];
            if (!fifo_full_i && !flush_i) e.ready[g] = 1'b1;
            e.push = req_valid_i[g] && !fifo_full_i && !flush_i;
        end
        if (flush_i) begin
            model_reset();
        end else if (e.push) begin
            accepted_id = g;
            beats_taken = in_packet ? beats_taken + 1 : 1;
            if (req_last_i[g] || beats_taken == MB) begin
                in_packet  = 1'b0;
                next_start = (g + 1) % NR;
            end else begin
                in_packet = 1'b1;
                holder    = g;
            end
        end
    endtask

    task automatic drive_requesters(input bit force_all);
        for (int i = 0; i < NR; i++) begin
            if (accepted_id == i) begin
                beat[i]++;
                up[i] = 1'b0;
                if (beat[i] == pkt_len[i]) begin
                    beat[i]    = 0;
                    pkt_len[i] = 1 + int'($urandom_range(11));
                    pkt_no[i]++;
                end
            end
            if (force_all) up[i] = 1'b1;
            else if (!up[i]) up[i] = ($urandom_range(9) < 7);
            req_valid_i[i]           = up[i];
            req_last_i[i]            = (beat[i] == pkt_len[i] - 1);
            req_data_i[i*DW +: DW]   = beat_data(i);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("push",   64'(fifo_push_o), 64'(e.push));
            chk("grant",  64'(grant_o),     64'(e.grant));
            chk("ready",  64'(req_ready_o), 64'(e.ready));
            chk("locked", 64'(locked_o),    64'(e.locked));
            chk("data",   64'(fifo_data_o), 64'(e.data));
        end
    end

    initial begin
        exp_t e;
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        fifo_full_i = 1'b0;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        accepted_id = -1;
        model_reset();
        for (int i = 0; i < NR; i++) begin
            pkt_len[i] = 1;
            beat[i]    = 0;
            pkt_no[i]  = 0;
            up[i]      = 1'b1;
        end
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            rst_ni = !(c < 2 || (c >= 2000 && c < 2002));
            if (c < 300) begin
                fifo_full_i = 1'b0;
                flush_i     = 1'b0;
            end else begin
                fifo_full_i = ($urandom_range(4) == 0);
                flush_i     = ($urandom_range(39) == 0);
            end
            drive_requesters(!rst_ni);
            model_step(e);
            q.push_back(e);
        end
        @(negedge clk);
        #1;
        chk("drain", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
